fracbnn_axil_ctrl: RTL
======================

Name: fracbnn_axil_ctrl

Overview:
- AXI4-Lite slave control/status block for the FracBNN IP.
- It is the stage directly downstream of the AXI VIP master in the IP's BFM design.
- Holds four 32-bit registers (control, two buffer addresses, status) and runs a start/busy/done handshake with the FracBNN compute core.
- Raises a level interrupt on completion.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI4-Lite data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; decode uses awaddr/araddr[3:2].

Ports:
- ACLK  in  1  system clock; all logic is on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- s_axi_awaddr  in  4  write address.
- s_axi_awprot  in  3  ignored.
- s_axi_awvalid  in  1  write-address valid.
- s_axi_awready  out  1  write-address ready.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  write byte enables.
- s_axi_wvalid  in  1  write-data valid.
- s_axi_wready  out  1  write-data ready.
- s_axi_bresp  out  2  write response; always 2'b00 (OKAY).
- s_axi_bvalid  out  1  write-response valid.
- s_axi_bready  in  1  write-response ready.
- s_axi_araddr  in  4  read address.
- s_axi_arprot  in  3  ignored.
- s_axi_arvalid  in  1  read-address valid.
- s_axi_arready  out  1  read-address ready.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response; always 2'b00 (OKAY).
- s_axi_rvalid  out  1  read-data valid.
- s_axi_rready  in  1  read-data ready.
- core_start  out  1  one-cycle start pulse to the compute core.
- core_src_addr  out  32  image buffer base address (mirrors SRC_ADDR).
- core_dst_addr  out  32  result buffer base address (mirrors DST_ADDR).
- core_done  in  1  one-cycle completion pulse from the core.
- irq  out  1  level interrupt, registered.

Behaviour:
- Register map:
  - 0x0 CTRL: bit0 START, write-1 to launch, reads 0. bit1 IRQ_EN, RW. Bits[31:2] read 0.
  - 0x4 SRC_ADDR: RW.
  - 0x8 DST_ADDR: RW.
  - 0xC STATUS: bit0 BUSY, RO. bit1 DONE, sticky, write-1-to-clear. Other bits read 0.
- Reset:
  - While ARESET is high, every output and register is 0 and the FSM is IDLE.
  - awready, wready and arready rise on the first ACLK edge after ARESET falls.
  - ARESET asserted mid-transaction or mid-RUN aborts everything with no B/R completion. Software must reset the core alongside this block.
- Write channel:
  - AW and W are accepted independently, each into a one-entry holding register.
  - awready = !aw_held; wready = !w_held.
  - When both are held and bvalid is low, the write commits in one cycle, both holds clear and bvalid rises on the next edge.
  - bvalid holds until bready; no new commit happens while bvalid is high.
  - AW before W, W before AW, and both in the same cycle all yield exactly one B.
  - WSTRB applies per byte on RW registers.
- Read channel:
  - arready = !rvalid.
  - rdata is registered with 1-cycle latency from the AR handshake and holds stable until rready.
  - A read issued in the same cycle as a write commit to the same address returns the old value.
- Core FSM:
  - States: IDLE, START, RUN.
  - IDLE to START: committed CTRL write with wdata[0]=1 and wstrb[0]=1.
  - START: core_start=1 for exactly one cycle, then go to RUN.
  - RUN: BUSY=1. On core_done, go to IDLE and set DONE.
  - A START write while in START or RUN is ignored (no pulse); IRQ_EN in that write still updates.
  - core_done in IDLE or START is ignored.
- DONE priority: if the DONE set and a W1C land in the same cycle, the set wins.
- irq is registered as IRQ_EN & DONE, so it rises 1 cycle after DONE sets.
- core_src_addr and core_dst_addr are the live register values; software must not change them during RUN.

Decomposition:
- Package fracbnn_ctrl_pkg holds:
  - register offset constants (CTRL, SRC_ADDR, DST_ADDR, STATUS);
  - bit-position constants (START, IRQ_EN, BUSY, DONE);
  - the FSM state enum (IDLE, START, RUN);
  - the OKAY response constant.
- One sub-module: fracbnn_axil_hold, a one-entry valid/ready holding register. It is instantiated twice, for AW (4 bits) and W (36 bits: data + strobe).

Test Plan:
- Write 0x4=0x1000_0000 and 0x8=0x2000_0000, then read both back: data matches, bresp/rresp 0, core_src_addr and core_dst_addr match.
- W presented 3 cycles before AW with data 0x0000_00A5 to 0x4: exactly one bvalid pulse, after which 0x4 reads 0x0000_00A5.
- SRC_ADDR=0, then write 0xAABB_CCDD with wstrb=4'b0010: readback is 0x0000_CC00.
- Write CTRL=0x3:
  - core_start pulses high for exactly one cycle; STATUS reads 0x1.
  - core_done pulse: STATUS reads 0x2, irq=1.
  - Write STATUS=0x2: irq=0, STATUS reads 0x0.
- During RUN, write CTRL=0x1: no core_start pulse, BUSY stays 1. Drive core_done in the same cycle as a W1C of STATUS: DONE reads 1 afterwards.
- Assert ARESET in RUN with an AW held: all outputs are 0, STATUS reads 0x0 after release, and awready/wready/arready are 1 one cycle later.

Source files
------------

// File: rtl/fracbnn_ctrl_pkg.sv
// Shared definitions for the FracBNN AXI4-Lite control block: register
// word offsets (address bits [3:2]), register bit positions, the core
// handshake FSM state type, the AXI OKAY response code, and a byte-strobe
// merge helper used by the read/write registers.
package fracbnn_ctrl_pkg;

  // Word index (address bits [3:2]) of each register
  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_SRC_ADDR = 2'd1;
  localparam logic [1:0] REG_DST_ADDR = 2'd2;
  localparam logic [1:0] REG_STATUS   = 2'd3;

  // CTRL register bits
  localparam int unsigned BIT_START  = 0;
  localparam int unsigned BIT_IRQ_EN = 1;

  // STATUS register bits
  localparam int unsigned BIT_BUSY = 0;
  localparam int unsigned BIT_DONE = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Replace each byte of old_val whose strobe bit is set with the same
  // byte of new_val
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) r[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/fracbnn_axil_hold.sv
// One-entry valid/ready holding register for an AXI4-Lite request channel.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   in_data   - payload presented by the master
//   in_valid  - master valid
//   in_ready  - slave ready; low during reset, while the entry is full,
//               and until the first clock edge after reset falls
//   pop       - consumer releases the held entry
//   held      - entry currently full
//   out_data  - held payload
module fracbnn_axil_hold #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         pop,
  output logic         held,
  output logic [W-1:0] out_data
);

  logic live;

  assign in_ready = live & ~held;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live     <= 1'b0;
      held     <= 1'b0;
      out_data <= '0;
    end else begin
      live <= 1'b1;
      if (pop) begin
        held <= 1'b0;
      end else if (in_valid && in_ready) begin
        held     <= 1'b1;
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/fracbnn_axil_ctrl.sv
// AXI4-Lite control/status slave for the FracBNN compute core.
// Registers: CTRL (START W1 pulse, IRQ_EN), SRC_ADDR, DST_ADDR,
// STATUS (BUSY RO, DONE sticky W1C). Drives a start/busy/done handshake to
// the core and a registered level interrupt (IRQ_EN & DONE).
// Ports:
//   ACLK, ARESET        - clock, asynchronous active-high reset
//   s_axi_aw*/w*/b*     - AXI4-Lite write channels (AW and W held separately)
//   s_axi_ar*/r*        - AXI4-Lite read channels (1-cycle registered read)
//   core_start          - one-cycle launch pulse to the core
//   core_src_addr/dst   - live SRC_ADDR / DST_ADDR register values
//   core_done           - one-cycle completion pulse from the core
//   irq                 - level interrupt
module fracbnn_axil_ctrl
  import fracbnn_ctrl_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic                            core_start,
  output logic [31:0]                     core_src_addr,
  output logic [31:0]                     core_dst_addr,
  input  logic                            core_done,
  output logic                            irq
);

  localparam int unsigned WW = C_S_AXI_DATA_WIDTH + C_S_AXI_DATA_WIDTH/8;

  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [WW-1:0]                 w_q;
  logic                          aw_held, w_held;
  logic                          commit;
  logic [1:0]                    wr_idx;
  logic [31:0]                   wr_data;
  logic [3:0]                    wr_strb;

  logic        live;
  logic        irq_en, done;
  logic [31:0] src_addr, dst_addr;
  logic [31:0] rd_mux;
  logic        ar_hs;
  logic        start_req, done_set, done_clr;
  state_t      state, state_next;

  logic unused;
  assign unused = ^{s_axi_awprot, s_axi_arprot, aw_addr_q[1:0], s_axi_araddr[1:0]};

  fracbnn_axil_hold #(.W(C_S_AXI_ADDR_WIDTH)) u_aw_hold (
    .clk      (ACLK),
    .rst      (ARESET),
    .in_data  (s_axi_awaddr),
    .in_valid (s_axi_awvalid),
    .in_ready (s_axi_awready),
    .pop      (commit),
    .held     (aw_held),
    .out_data (aw_addr_q)
  );

  fracbnn_axil_hold #(.W(WW)) u_w_hold (
    .clk      (ACLK),
    .rst      (ARESET),
    .in_data  ({s_axi_wstrb, s_axi_wdata}),
    .in_valid (s_axi_wvalid),
    .in_ready (s_axi_wready),
    .pop      (commit),
    .held     (w_held),
    .out_data (w_q)
  );

  // A commit waits for any outstanding B to drain, so at most one B is in flight
  assign commit  = aw_held & w_held & ~s_axi_bvalid;
  assign wr_idx  = aw_addr_q[3:2];
  assign wr_data = w_q[31:0];
  assign wr_strb = w_q[35:32];

  assign s_axi_bresp   = RESP_OKAY;
  assign s_axi_rresp   = RESP_OKAY;
  assign s_axi_arready = live & ~s_axi_rvalid;
  assign ar_hs         = s_axi_arvalid & s_axi_arready;

  assign core_src_addr = src_addr;
  assign core_dst_addr = dst_addr;

  assign start_req = commit && (wr_idx == REG_CTRL) && wr_strb[0] && wr_data[BIT_START];
  assign done_clr  = commit && (wr_idx == REG_STATUS) && wr_strb[0] && wr_data[BIT_DONE];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    core_start = 1'b0;
    done_set   = 1'b0;
    case (state)
      ST_IDLE:  if (start_req) state_next = ST_START;
      ST_START: begin
        core_start = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: if (core_done) begin
        done_set   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (s_axi_araddr[3:2])
      REG_CTRL:     rd_mux[BIT_IRQ_EN] = irq_en;
      REG_SRC_ADDR: rd_mux = src_addr;
      REG_DST_ADDR: rd_mux = dst_addr;
      REG_STATUS: begin
        rd_mux[BIT_BUSY] = (state == ST_RUN);
        rd_mux[BIT_DONE] = done;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      live         <= 1'b0;
      irq_en       <= 1'b0;
      done         <= 1'b0;
      irq          <= 1'b0;
      src_addr     <= '0;
      dst_addr     <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
    end else begin
      live <= 1'b1;

      if (commit) begin
        case (wr_idx)
          REG_CTRL:     if (wr_strb[0]) irq_en <= wr_data[BIT_IRQ_EN];
          REG_SRC_ADDR: src_addr <= apply_wstrb(src_addr, wr_data, wr_strb);
          REG_DST_ADDR: dst_addr <= apply_wstrb(dst_addr, wr_data, wr_strb);
          default: ;
        endcase
      end

      // Completion from the core outranks a simultaneous software clear
      if (done_set)      done <= 1'b1;
      else if (done_clr) done <= 1'b0;

      irq <= irq_en & done;

      if (commit)            s_axi_bvalid <= 1'b1;
      else if (s_axi_bready) s_axi_bvalid <= 1'b0;

      // rd_mux sees pre-commit register values, so a colliding read returns old data
      if (ar_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_mux;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule
